// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared pipeline package: fetch FSM states, IF/ID bundle and small helpers.
package instr_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2,
    ST_FULL = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  // IF/ID pipeline bundle, also consumed by ID-stage blocks.
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc1;
  } ifid_t;

  // Word-addressed successor PC; wraps 32'hFFFF_FFFF to 0.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Split-transaction instruction memory port: request/grant plus response.
interface instr_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_ctrl_skid.sv
// One-entry skid buffer in front of the IF/ID register.
// flush beats everything, then a direct load, then a buffer pop; otherwise
// the register bubbles unless hold is asserted.
module ifid_skid_reg
  import instr_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        flush,
  input  logic        hold,
  input  logic        bypass_ld,
  input  logic        skid_ld,
  input  logic        skid_pop,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc1,
  output ifid_t       ifid
);

  logic [31:0] skid_instr_p0;
  logic [31:0] skid_pc1_p0;
  ifid_t       ifid_p1;

  // Skid entry: captures a response that decode cannot take yet.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      skid_instr_p0 <= '0;
      skid_pc1_p0   <= '0;
    end else if (skid_ld) begin
      skid_instr_p0 <= in_instr;
      skid_pc1_p0   <= in_pc1;
    end
  end

  // IF/ID register: flush > direct load > pop > bubble, held while stalled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ifid_p1.valid <= 1'b0;
      ifid_p1.instr <= NOP_INSTR;
      ifid_p1.pc1   <= '0;
    end else if (flush) begin
      ifid_p1.valid <= 1'b0;
      ifid_p1.instr <= NOP_INSTR;
    end else if (bypass_ld) begin
      ifid_p1.valid <= 1'b1;
      ifid_p1.instr <= in_instr;
      ifid_p1.pc1   <= in_pc1;
    end else if (skid_pop) begin
      ifid_p1.valid <= 1'b1;
      ifid_p1.instr <= skid_instr_p0;
      ifid_p1.pc1   <= skid_pc1_p0;
    end else if (!hold) begin
      ifid_p1.valid <= 1'b0;
      ifid_p1.instr <= NOP_INSTR;
    end
  end

  assign ifid = ifid_p1;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch controller: issues one fetch at a time to the
// instruction memory, feeds IF/ID, stalls the PC until delivery or
// redirect, and squashes wrong-path responses after a redirect.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [31:0]        PC,
  input  logic               PCsrc,
  input  logic               DecStall,
  output logic               Stall,
  instr_fetch_ctrl_if.master imem,
  output logic               IFID_valid,
  output logic [31:0]        IFID_instr,
  output logic [31:0]        IFID_PC1
);

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic [31:0]  fpc_q;
  logic [31:0]  fpc_inc;
  logic         req_c;
  logic         granted;
  logic         deliver_now;
  logic         skid_ld;
  logic         skid_pop;
  ifid_t        ifid;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_REQ;
    else     state_q <= state_d;
  end

  // Address of the in-flight fetch, captured when memory accepts it.
  always_ff @(posedge CLK) begin
    if (granted) fpc_q <= PC;
  end

  // Next state; a redirect leaves DROP behind whenever a request is still
  // in flight (including one granted in this very cycle).
  always_comb begin
    state_d = state_q;
    if (PCsrc) begin
      unique case (state_q)
        ST_REQ:           state_d = imem.imem_gnt    ? ST_DROP : ST_REQ;
        ST_WAIT, ST_DROP: state_d = imem.imem_rvalid ? ST_REQ  : ST_DROP;
        default:          state_d = ST_REQ;
      endcase
    end else begin
      unique case (state_q)
        ST_REQ:  if (imem.imem_gnt)    state_d = ST_WAIT;
        ST_WAIT: if (imem.imem_rvalid) state_d = DecStall ? ST_FULL : ST_REQ;
        ST_DROP: if (imem.imem_rvalid) state_d = ST_REQ;
        default: if (!DecStall)        state_d = ST_REQ;
      endcase
    end
  end

  // Outputs and datapath strobes; redirect suppresses any delivery.
  always_comb begin
    req_c       = 1'b0;
    granted     = 1'b0;
    deliver_now = 1'b0;
    skid_ld     = 1'b0;
    skid_pop    = 1'b0;
    unique case (state_q)
      ST_REQ: begin
        req_c   = 1'b1;
        granted = imem.imem_gnt;
      end
      ST_WAIT: begin
        deliver_now = imem.imem_rvalid & !DecStall & !PCsrc;
        skid_ld     = imem.imem_rvalid &  DecStall & !PCsrc;
      end
      ST_FULL: skid_pop = !DecStall & !PCsrc;
      default: ;
    endcase
    Stall = !(deliver_now | skid_pop | PCsrc);
  end

  assign imem.imem_req  = req_c;
  assign imem.imem_addr = PC;
  assign fpc_inc        = pc_next(fpc_q);

  ifid_skid_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_skid (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (PCsrc),
    .hold      (DecStall),
    .bypass_ld (deliver_now),
    .skid_ld   (skid_ld),
    .skid_pop  (skid_pop),
    .in_instr  (imem.imem_rdata),
    .in_pc1    (fpc_inc),
    .ifid      (ifid)
  );

  assign IFID_valid = ifid.valid;
  assign IFID_instr = ifid.instr;
  assign IFID_PC1   = ifid.pc1;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a latency-programmable memory
// and a simple program-counter model driving PC.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST;
  logic        PCsrc;
  logic        DecStall;
  logic [31:0] PC;
  logic [31:0] target;
  logic        Stall;
  logic        IFID_valid;
  logic [31:0] IFID_instr;
  logic [31:0] IFID_PC1;

  logic        gnt_en;
  int unsigned lat;
  logic        m_pend;
  int unsigned m_cnt;
  logic [31:0] m_addr;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_ctrl_if imem_bus();

  instr_fetch_ctrl #(.NOP_INSTR(NOP)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PC         (PC),
    .PCsrc      (PCsrc),
    .DecStall   (DecStall),
    .Stall      (Stall),
    .imem       (imem_bus),
    .IFID_valid (IFID_valid),
    .IFID_instr (IFID_instr),
    .IFID_PC1   (IFID_PC1)
  );

  always #5 CLK = ~CLK;

  // Memory: grants immediately when enabled, answers lat cycles after grant.
  always_comb imem_bus.imem_gnt = gnt_en & imem_bus.imem_req & ~m_pend;
  assign imem_bus.imem_rvalid = m_pend && (m_cnt == 0);
  assign imem_bus.imem_rdata  = (m_pend && m_cnt == 0) ? 32'h2000_0000 + m_addr : 32'hDEAD_BEEF;

  always @(posedge CLK) begin
    if (RST) begin
      m_pend <= 1'b0;
      m_cnt  <= 0;
    end else if (imem_bus.imem_gnt) begin
      m_pend <= 1'b1;
      m_cnt  <= lat - 1;
      m_addr <= imem_bus.imem_addr;
    end else if (m_pend) begin
      if (m_cnt == 0) m_pend <= 1'b0;
      else            m_cnt  <= m_cnt - 1;
    end
  end

  // Program counter: loads the target on redirect, advances when not stalled.
  always @(posedge CLK) begin
    if (RST)         PC <= 32'd0;
    else if (PCsrc)  PC <= target;
    else if (!Stall) PC <= PC + 32'd1;
  end

  task automatic assert_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One unobstructed fetch: REQ cycle with grant, rvalid cycle, then IF/ID.
  task automatic fetch_one(input logic [31:0] a);
    logic [31:0] pc1;
    pc1 = a + 32'd1;
    assert_eq("fetch_req",       {31'd0, imem_bus.imem_req}, 32'd1);
    assert_eq("fetch_addr",      imem_bus.imem_addr, a);
    assert_eq("fetch_req_stall", {31'd0, Stall}, 32'd1);
    tick(); settle();
    assert_eq("fetch_rv_stall",  {31'd0, Stall}, 32'd0);
    assert_eq("fetch_rv_req",    {31'd0, imem_bus.imem_req}, 32'd0);
    tick(); settle();
    assert_eq("fetch_valid",     {31'd0, IFID_valid}, 32'd1);
    assert_eq("fetch_instr",     IFID_instr, 32'h2000_0000 + a);
    assert_eq("fetch_pc1",       IFID_PC1, pc1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; PCsrc = 1'b0; DecStall = 1'b0; target = '0;
    gnt_en = 1'b1; lat = 1;

    // Reset, then straight-line fetch of 0,1,2,3.
    tick(); tick(); settle();
    assert_eq("rst_valid", {31'd0, IFID_valid}, 32'd0);
    assert_eq("rst_instr", IFID_instr, NOP);
    assert_eq("rst_pc1",   IFID_PC1, 32'd0);
    RST = 1'b0;
    settle();
    assert_eq("post_rst_req",   {31'd0, imem_bus.imem_req}, 32'd1);
    assert_eq("post_rst_stall", {31'd0, Stall}, 32'd1);
    for (int k = 0; k < 4; k++) fetch_one(k);

    // Decode stall across the response for address 4.
    DecStall = 1'b1; settle();
    assert_eq("ds_req_addr", imem_bus.imem_addr, 32'd4);
    tick(); settle();
    assert_eq("ds_rv_stall", {31'd0, Stall}, 32'd1);
    assert_eq("ds_rv_hold",  IFID_PC1, 32'd4);
    tick(); settle();
    assert_eq("ds_full_req",   {31'd0, imem_bus.imem_req}, 32'd0);
    assert_eq("ds_full_stall", {31'd0, Stall}, 32'd1);
    assert_eq("ds_full_instr", IFID_instr, 32'h2000_0003);
    assert_eq("ds_full_valid", {31'd0, IFID_valid}, 32'd1);
    tick(); DecStall = 1'b0; settle();
    assert_eq("ds_rel_stall", {31'd0, Stall}, 32'd0);
    assert_eq("ds_rel_req",   {31'd0, imem_bus.imem_req}, 32'd0);
    tick(); settle();
    assert_eq("ds_pop_instr", IFID_instr, 32'h2000_0004);
    assert_eq("ds_pop_pc1",   IFID_PC1, 32'd5);
    assert_eq("ds_pop_valid", {31'd0, IFID_valid}, 32'd1);
    fetch_one(5);
    fetch_one(6);

    // Redirect while waiting for address 7 (slow response).
    lat = 3; settle();
    assert_eq("rw_addr", imem_bus.imem_addr, 32'd7);
    tick(); PCsrc = 1'b1; target = 32'h40; settle();
    assert_eq("rw_stall", {31'd0, Stall}, 32'd0);
    tick(); PCsrc = 1'b0; settle();
    assert_eq("rw_flush_valid", {31'd0, IFID_valid}, 32'd0);
    assert_eq("rw_flush_instr", IFID_instr, NOP);
    assert_eq("rw_drop_req",    {31'd0, imem_bus.imem_req}, 32'd0);
    tick(); settle();
    assert_eq("rw_stale_rv",    {31'd0, imem_bus.imem_rvalid}, 32'd1);
    assert_eq("rw_stale_req",   {31'd0, imem_bus.imem_req}, 32'd0);
    assert_eq("rw_stale_stall", {31'd0, Stall}, 32'd1);
    tick(); settle();
    assert_eq("rw_no_stale",  {31'd0, IFID_valid}, 32'd0);
    assert_eq("rw_tgt_req",   {31'd0, imem_bus.imem_req}, 32'd1);
    lat = 1;
    fetch_one(32'h40);

    // Redirect coincident with grant: stale request goes to DROP.
    PCsrc = 1'b1; target = 32'h80; settle();
    assert_eq("rg_stall", {31'd0, Stall}, 32'd0);
    tick(); PCsrc = 1'b0; settle();
    assert_eq("rg_drop_req",   {31'd0, imem_bus.imem_req}, 32'd0);
    assert_eq("rg_drop_stall", {31'd0, Stall}, 32'd1);
    assert_eq("rg_drop_valid", {31'd0, IFID_valid}, 32'd0);
    tick(); settle();
    assert_eq("rg_after_valid", {31'd0, IFID_valid}, 32'd0);
    fetch_one(32'h80);

    // Redirect coincident with the response: straight back to REQ.
    tick(); PCsrc = 1'b1; target = 32'hC0; settle();
    assert_eq("rr_stall", {31'd0, Stall}, 32'd0);
    tick(); PCsrc = 1'b0; settle();
    assert_eq("rr_req",   {31'd0, imem_bus.imem_req}, 32'd1);
    assert_eq("rr_valid", {31'd0, IFID_valid}, 32'd0);
    assert_eq("rr_instr", IFID_instr, NOP);
    fetch_one(32'hC0);

    // Redirect while a buffered instruction waits behind DecStall.
    tick(); DecStall = 1'b1; settle();
    assert_eq("rf_rv_stall", {31'd0, Stall}, 32'd1);
    tick(); PCsrc = 1'b1; target = 32'h100; settle();
    assert_eq("rf_full_req", {31'd0, imem_bus.imem_req}, 32'd0);
    assert_eq("rf_stall",    {31'd0, Stall}, 32'd0);
    tick(); PCsrc = 1'b0; DecStall = 1'b0; settle();
    assert_eq("rf_valid", {31'd0, IFID_valid}, 32'd0);
    assert_eq("rf_instr", IFID_instr, NOP);
    fetch_one(32'h100);

    // Fetch at the top of the address space: PC1 wraps to 0.
    gnt_en = 1'b0; PCsrc = 1'b1; target = 32'hFFFF_FFFF; settle();
    tick(); PCsrc = 1'b0; gnt_en = 1'b1; settle();
    fetch_one(32'hFFFF_FFFF);

    // Reset while waiting: everything returns to reset values.
    lat = 3; settle();
    tick(); settle();
    assert_eq("rmw_wait_req", {31'd0, imem_bus.imem_req}, 32'd0);
    RST = 1'b1;
    tick(); RST = 1'b0; settle();
    assert_eq("rmw_req",   {31'd0, imem_bus.imem_req}, 32'd1);
    assert_eq("rmw_stall", {31'd0, Stall}, 32'd1);
    assert_eq("rmw_valid", {31'd0, IFID_valid}, 32'd0);
    assert_eq("rmw_instr", IFID_instr, NOP);
    assert_eq("rmw_pc1",   IFID_PC1, 32'd0);
    lat = 1;
    fetch_one(32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Instruction-fetch controller at the consumer end of the program counter interface. It reads the current `PC`, fetches the instruction from a split-transaction instruction memory, and drives the IF/ID pipeline register. It returns `Stall` to the program counter so the PC advances only when an instruction is delivered or a redirect (`PCsrc`) occurs. It owns wrong-path squashing: it flushes IF/ID and discards stale memory responses.

## Interface
- `NOP_INSTR`, default `32'h0000_0000`: instruction word loaded into IF/ID on reset, flush or bubble.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `PC` in 32: current word address from the program counter.
- `PCsrc` in 1: redirect this cycle. The program counter loads its target when `Stall`=0.
- `DecStall` in 1: decode hazard stall. IF/ID must hold its contents.
- `Stall` out 1: hold the program counter (combinational).
- `imem_req` out 1: fetch request valid (combinational).
- `imem_addr` out 32: fetch address, equal to `PC` while `imem_req` is high.
- `imem_gnt` in 1: request accepted this cycle (valid/ready on `imem_req`).
- `imem_rvalid` in 1: response data valid. At most one request is outstanding.
- `imem_rdata` in 32: instruction word.
- `IFID_valid` out 1: IF/ID holds a real instruction.
- `IFID_instr` out 32: IF/ID instruction.
- `IFID_PC1` out 32: address of the IF/ID instruction plus 1 (word addressing).

## Operation
- **States**
  - REQ: request is driven.
  - WAIT: accepted, awaiting the response.
  - DROP: stale request outstanding; its response will be discarded.
  - FULL: one instruction buffered because `DecStall` was high.
- **Fetch PC.** `fpc` is latched from `PC` on grant.
- **Priority.** `RST` > `PCsrc` > delivery/stall logic.
- **REQ**
  - `imem_req`=1, `imem_addr`=`PC`.
  - The request may change or be withdrawn before grant.
  - On `imem_gnt`, go to WAIT, or to DROP if `PCsrc`=1 in the same cycle.
- **WAIT**
  - `rvalid` & !`DecStall`: deliver. IF/ID ← {1, `rdata`, `fpc`+1}, `Stall`=0, go to REQ.
  - `rvalid` & `DecStall`: buffer ← {`rdata`, `fpc`+1}, go to FULL.
- **DROP**
  - No request is issued.
  - On `rvalid`, discard the data and go to REQ.
- **FULL**
  - No request is issued.
  - When `DecStall`=0, IF/ID ← buffer, `Stall`=0, go to REQ.
- **Stall.** `Stall` = !(deliver | `PCsrc`). The PC moves only on delivery or redirect.
- **PCsrc** (any state)
  - Flushes IF/ID: valid=0, instr=`NOP_INSTR`. This overrides `DecStall`.
  - Empties the buffer.
  - Any response arriving in the same cycle is discarded.
  - Next state: DROP if a request is still outstanding and was not completed this cycle, otherwise REQ.
  - A grant in REQ in the same cycle counts as outstanding.
- **IF/ID update**
  - With `DecStall`=0 and no delivery, IF/ID loads a bubble (valid=0, `NOP_INSTR`).
  - With `DecStall`=1 and no `PCsrc`, IF/ID holds.
- **Width rule.** `fpc`+1 is a 32-bit wrap: `32'hFFFF_FFFF` → 0.

## Timing
- **Reset values**
  - state = REQ, `IFID_valid`=0, `IFID_instr`=`NOP_INSTR`, `IFID_PC1`=0, buffer cleared.
  - Outputs in the first cycle after reset: `imem_req`=1, `Stall`=1.
  - A reset mid-transaction abandons the outstanding request. The memory is reset by the same `RST`.
- **Best-case throughput.** With gnt in REQ and rvalid in the next cycle, one instruction is delivered every 2 cycles. IF/ID updates at the end of the rvalid cycle.
- **Redirect latency.** Target fetch is requested in the cycle after `PCsrc`, from REQ. From DROP, it is requested in the cycle after the stale `rvalid`.
- **Outstanding limit.** `imem_gnt` is only sampled in REQ. `imem_rvalid` outside WAIT/DROP is a protocol error and is ignored.

## Structure
- **Shared package** (pipeline package) holds:
  - the fetch state enum (REQ, WAIT, DROP, FULL);
  - the `NOP_INSTR` default;
  - the IF/ID bundle typedef {valid, instr[31:0], pc1[31:0]}, reused by ID-stage blocks.
- **Sub-module** `ifid_skid_reg`: one-entry skid buffer plus IF/ID register with load/hold/flush controls. The FSM and `Stall`/`imem_req` logic stay in the top level.

## Test plan
- **Reset then straight-line fetch.** `RST` for 2 cycles; memory grants immediately with rvalid 1 cycle later and rdata = `32'h2000_0000`+addr. Expect:
  - `imem_addr` sequence 0,1,2;
  - `IFID_PC1` sequence 1,2,3;
  - `Stall`=0 only in rvalid cycles.
- **Decode stall.** Hold `DecStall`=1 for 3 cycles during rvalid of addr 4. Expect:
  - IF/ID keeps addr-3 data;
  - state FULL, `imem_req`=0, `Stall`=1;
  - on release, IF/ID gets addr-4 data with `PC1`=5.
- **Redirect in WAIT.** `PCsrc`=1 while waiting for addr 7, rvalid delayed 3 cycles. Expect:
  - IF/ID flushed to `NOP_INSTR`, valid=0;
  - the stale addr-7 data is never delivered;
  - next request is at the target (e.g. `32'h40`) after the stale rvalid.
- **Redirect coincident with gnt and with rvalid.** Expect DROP and REQ respectively, with no valid instruction from the old path.
- **Redirect during FULL with `DecStall`=1.** Expect the buffer discarded, IF/ID flushed, and the next `imem_addr` equal to the target.
- **Wrap and reset mid-WAIT.** Fetch at `32'hFFFF_FFFF` → `IFID_PC1`=0. Asserting `RST` in WAIT → all outputs return to their reset values.
